// File: rtl/tile_line_renderer.sv
// tile_line_renderer: fetches one tile-map row per line into a ping-pong
// line buffer and serves registered, scrollable RGB pixels from the other half.
//
// Ports:
//   vga_clk, sys_rst          pixel clock, synchronous active-high reset
//   line_start, line_y        strobe to prepare visible line line_y
//   scroll_x, scroll_y        pixel scroll, latched on line_start at line 0
//   de, pix_x                 current active-video pixel
//   map_addr / map_data       tilemap RAM port (1-cycle read latency)
//   tile_addr / tile_data     tile ROM port {idx,row,col} (1-cycle latency)
//   rgb                       registered pixel output
//   fill_busy, overrun        fill in progress / sticky restart-while-busy
module tile_line_renderer #(
   parameter int TILE_W   = 16,
   parameter int TILE_H   = 16,
   parameter int MAP_COLS = 40,
   parameter int MAP_ROWS = 30,
   parameter int IDX_W    = 8,
   parameter int PIX_W    = 16
) (
   input  logic                     vga_clk,
   input  logic                     sys_rst,
   input  logic                     line_start,
   input  logic [9:0]               line_y,
   input  logic [15:0]              scroll_x,
   input  logic [15:0]              scroll_y,
   input  logic                     de,
   input  logic [9:0]               pix_x,
   output logic [$clog2(MAP_COLS*MAP_ROWS)-1:0] map_addr,
   input  logic [IDX_W-1:0]         map_data,
   output logic [IDX_W+$clog2(TILE_H)+$clog2(TILE_W)-1:0] tile_addr,
   input  logic [PIX_W-1:0]         tile_data,
   output logic [PIX_W-1:0]         rgb,
   output logic                     fill_busy,
   output logic                     overrun
);

   localparam int TWB      = $clog2(TILE_W);
   localparam int THB      = $clog2(TILE_H);
   localparam int MAW      = $clog2(MAP_COLS*MAP_ROWS);
   localparam int LINE_PIX = MAP_COLS*TILE_W;
   localparam int LBA      = $clog2(LINE_PIX);
   localparam int COLW     = $clog2(MAP_COLS);
   localparam int ROWW     = 17-THB;

   localparam logic [16:0] MAP_H  = 17'(MAP_ROWS*TILE_H);
   localparam logic [16:0] LINE_W = 17'(LINE_PIX);

   typedef enum logic [2:0] {
      IDLE, MAP, WAIT, PIX, DRAIN
   } state_t;

   // Restoring remainder: compare-subtract of m shifted down from 2^16.
   function automatic logic [16:0] modRed(
      input logic [16:0] v,
      input logic [16:0] m
   );
      logic [33:0] r;
      logic [33:0] sh;
      r = {17'd0, v};
      for (int k = 16; k >= 0; k--) begin
         sh = {17'd0, m} << k;
         if (r >= sh) r = r - sh;
      end
      return r[16:0];
   endfunction

   state_t            state;
   logic [COLW-1:0]   col;
   logic [TWB-1:0]    px;
   logic [IDX_W-1:0]  idx;
   logic [THB-1:0]    tileRow;
   logic              wrBank;
   logic [16:0]       sx;
   logic [16:0]       sy;
   logic              wrPend;
   logic [LBA-1:0]    wrAddr;

   logic [PIX_W-1:0]  lineBuf [2][LINE_PIX];

   logic [16:0]       syNext;
   logic [16:0]       yPos;
   logic [ROWW-1:0]   rowNew;
   logic [MAW-1:0]    rowBase;
   logic [16:0]       rdSum;
   logic [LBA-1:0]    rdAddr;
   logic              lastPx;
   logic              lastCol;

   // The fill for line 0 must already see the scroll being latched with it.
   assign syNext  = (line_y == 10'd0)
                  ? modRed({1'b0, scroll_y}, MAP_H) : sy;
   assign yPos    = modRed({7'd0, line_y} + syNext, MAP_H);
   assign rowNew  = yPos[16:THB];
   assign rowBase = MAW'(rowNew * MAP_COLS);
   assign rdSum   = modRed({7'd0, pix_x} + sx, LINE_W);
   assign rdAddr  = rdSum[LBA-1:0];
   assign lastPx  = (px == TWB'(TILE_W-1));
   assign lastCol = (col == COLW'(MAP_COLS-1));

   // Tile data arrives one cycle after its address, hence the delayed write.
   always_ff @(posedge vga_clk) begin
      if (wrPend) lineBuf[wrBank][wrAddr] <= tile_data;
   end

   always_ff @(posedge vga_clk) begin
      if (sys_rst) begin
         state     <= IDLE;
         col       <= '0;
         px        <= '0;
         idx       <= '0;
         tileRow   <= '0;
         wrBank    <= 1'b0;
         sx        <= '0;
         sy        <= '0;
         wrPend    <= 1'b0;
         wrAddr    <= '0;
         rgb       <= '0;
         map_addr  <= '0;
         tile_addr <= '0;
         fill_busy <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         rgb    <= de ? lineBuf[~wrBank][rdAddr] : '0;
         wrPend <= 1'b0;
         if (line_start) begin
            if (line_y == 10'd0) begin
               sx <= modRed({1'b0, scroll_x}, LINE_W);
               sy <= syNext;
            end
            // A strobe on the DRAIN cycle means the fill just completed.
            if (fill_busy && state != DRAIN) overrun <= 1'b1;
            wrBank    <= ~wrBank;
            state     <= MAP;
            col       <= '0;
            px        <= '0;
            tileRow   <= yPos[THB-1:0];
            map_addr  <= rowBase;
            fill_busy <= 1'b1;
         end else begin
            unique case (state)
               IDLE: ;
               MAP:  state <= WAIT;
               WAIT: begin
                  idx       <= map_data;
                  tile_addr <= {map_data, tileRow, TWB'(0)};
                  px        <= '0;
                  state     <= PIX;
               end
               PIX: begin
                  wrPend <= 1'b1;
                  wrAddr <= {col, px};
                  if (!lastPx) begin
                     px        <= px + 1'b1;
                     tile_addr <= {idx, tileRow, px + 1'b1};
                  end else if (!lastCol) begin
                     col      <= col + 1'b1;
                     map_addr <= map_addr + 1'b1;
                     state    <= MAP;
                  end else begin
                     state <= DRAIN;
                  end
               end
               DRAIN: begin
                  state     <= IDLE;
                  fill_busy <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
